mix_accum: RTL

Per-frame mixing accumulator sitting directly downstream of the `mpemu` gain multiplier. It consumes the stream of signed 24-bit channel products (sample × gain) for one audio frame, sums them in a guarded-width accumulator, and emits one saturated 24-bit mixed sample per frame with a one-cycle valid strobe. Its output feeds the output serializer/DAC interface stage.

---
 rtl/mix_accum_if.sv | 25 ++
 rtl/mix_accum.sv | 98 +++++++++
 2 files changed

// File: rtl/mix_accum_if.sv
// Product-stream and mixed-sample bus for mix_accum.
// The master drives products and the error clear; the slave returns the mixed result.
interface mix_accum_if #(
   parameter int DATA_W = 24
);
   logic [DATA_W-1:0] prod_i;
   logic              prod_valid_i;
   logic              prod_last_i;
   logic              err_clr_i;
   logic [DATA_W-1:0] mix_o;
   logic              mix_valid_o;
   logic              clip_o;
   logic              ovr_err_o;
   logic [15:0]       clip_cnt_o;

   modport master (
      output prod_i, prod_valid_i, prod_last_i, err_clr_i,
      input  mix_o, mix_valid_o, clip_o, ovr_err_o, clip_cnt_o
   );

   modport slave (
      input  prod_i, prod_valid_i, prod_last_i, err_clr_i,
      output mix_o, mix_valid_o, clip_o, ovr_err_o, clip_cnt_o
   );
endinterface

// File: rtl/mix_accum.sv
// Per-frame mixing accumulator: sums signed channel products and emits one saturated sample per frame.
// Define MIX_ACCUM_CLIP_COUNT_EN to build the saturating clip-event counter on clip_cnt_o.
module mix_accum #(
   parameter int NUM_CH = 4,
   parameter int GUARD  = 4,
   parameter int DATA_W = 24
) (
   input  logic        clk,
   input  logic        rst,
   mix_accum_if.slave  bus
);
   localparam int ACC_W = DATA_W + GUARD;
   localparam int CNT_W = $clog2(NUM_CH + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(NUM_CH);
   localparam logic [0:0] IDLE  = 1'b0;
   localparam logic [0:0] ACCUM = 1'b1;

   // Sum is out of range when the guard bits plus the result sign bit disagree.
   function automatic logic is_clip(input logic signed [ACC_W-1:0] s);
      return !((&s[ACC_W-1:DATA_W-1]) || !(|s[ACC_W-1:DATA_W-1]));
   endfunction

   function automatic logic [DATA_W-1:0] sat(input logic signed [ACC_W-1:0] s);
      if (is_clip(s))
         return {s[ACC_W-1], {(DATA_W-1){~s[ACC_W-1]}}};
      return s[DATA_W-1:0];
   endfunction

   logic signed [ACC_W-1:0] acc;
   logic [CNT_W-1:0]        ch_cnt;
   logic [0:0]              state;
   logic signed [ACC_W-1:0] prod_ext;
   logic signed [ACC_W-1:0] base;
   logic signed [ACC_W-1:0] sum_p0;
   logic                    overrun;
   logic                    close;
   logic [DATA_W-1:0]       mix_p1;
   logic                    clip_p1;
   logic                    vld_p1;
   logic                    ovr_err;

   assign state    = (ch_cnt == '0) ? IDLE : ACCUM;
   assign prod_ext = {{GUARD{bus.prod_i[DATA_W-1]}}, bus.prod_i};
   assign base     = (state == ACCUM) ? acc : '0;
   assign overrun  = bus.prod_valid_i && (ch_cnt == CNT_MAX);
   assign close    = bus.prod_valid_i && bus.prod_last_i;
   // An overrun beat is dropped, so it contributes nothing to the closing sum.
   assign sum_p0   = overrun ? base : base + prod_ext;

   // p0 -> p1: accumulate, or close the frame into the output register
   always_ff @(posedge clk) begin
      if (rst) begin
         acc     <= '0;
         ch_cnt  <= '0;
         mix_p1  <= '0;
         clip_p1 <= 1'b0;
         vld_p1  <= 1'b0;
         ovr_err <= 1'b0;
      end else begin
         vld_p1  <= 1'b0;
         clip_p1 <= 1'b0;
         if (close) begin
            mix_p1  <= sat(sum_p0);
            clip_p1 <= is_clip(sum_p0);
            vld_p1  <= 1'b1;
            acc     <= '0;
            ch_cnt  <= '0;
         end else if (bus.prod_valid_i && !overrun) begin
            acc    <= sum_p0;
            ch_cnt <= ch_cnt + 1'b1;
         end
         if (overrun)
            ovr_err <= 1'b1;
         else if (bus.err_clr_i)
            ovr_err <= 1'b0;
      end
   end

   assign bus.mix_o       = mix_p1;
   assign bus.clip_o      = clip_p1;
   assign bus.mix_valid_o = vld_p1;
   assign bus.ovr_err_o   = ovr_err;

`ifdef MIX_ACCUM_CLIP_COUNT_EN
   logic [15:0] clip_cnt;

   always_ff @(posedge clk) begin
      if (rst || bus.err_clr_i)
         clip_cnt <= '0;
      else if (close && is_clip(sum_p0) && clip_cnt != 16'hFFFF)
         clip_cnt <= clip_cnt + 1'b1;
   end

   assign bus.clip_cnt_o = clip_cnt;
`else
   assign bus.clip_cnt_o = '0;
`endif
endmodule
